serial_adder_multbit: RTL and testbench
=======================================

Name: serial_adder_multbit

Overview:
- Bit-serial N-bit adder: the inverse operation of the team's gate-level multibit subtractor, and its sequential counterpart.
- Accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake.
- Adds LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake.
- Used as a sequential fault-simulation target and as a round-trip checker (a - b + b == a) alongside the subtractor.

Parameters:
WIDTH, 4, operand/sum width in bits (>= 2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  augend
b  input  WIDTH  addend
cin  input  1  carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - Internal shift registers, carry flip-flop and bit counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: load a_sr <= a, b_sr <= b, carry <= cin, cnt <= 0, sum_sr <= 0; go to SHIFT.
- SHIFT:
  - in_ready = 0; in_valid and the operand inputs are ignored.
  - Each edge computes bit = a_sr[0] ^ b_sr[0] ^ carry and carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by 1; sum_sr shifts right with bit entering at MSB; cnt increments.
  - On the edge where cnt == WIDTH-1: capture ovf <= carry_in_to_msb ^ carry_out, cout <= carry_out; go to DONE.
- DONE:
  - out_valid = 1; sum, cout, ovf held stable until out_ready = 1.
  - in_ready = out_ready, so the next operand set can be accepted on the same edge that the result is consumed.
  - out_ready = 1 and in_valid = 1: load new operands, go to SHIFT. out_valid drops for at least WIDTH cycles.
  - out_ready = 1 and in_valid = 0: go to IDLE.
  - out_ready = 0: stay in DONE; new operands are not accepted.
- Latency: exactly WIDTH clocks from the accepting edge to out_valid high. Throughput: one result per WIDTH+1 clocks with no backpressure.
- The sum output port shows the final result only while out_valid = 1. Between results it holds the last delivered value (0 after reset).
- in_valid asserted in SHIFT is not an error. The producer holds it until in_ready is seen.
- Width rule: the internal counter is clog2(WIDTH) bits. There is no wrap beyond WIDTH-1; the state exits SHIFT at WIDTH-1.
- rst_n assertion in any state, including mid-SHIFT or DONE with out_valid high, returns all state to reset values immediately. The partial result is discarded and never presented.
- X on a or b is never sampled outside the IDLE (or DONE with out_ready = 1) accept edge.

Test Plan (WIDTH = 4):
- Reset then a=7, b=5, cin=0, in_valid 1 cycle -> in_ready low 4 cycles; out_valid after exactly 4 clocks with sum=12, cout=0, ovf=1.
- a=15, b=1, cin=0 -> sum=0, cout=1, ovf=0. Then a=8, b=8 -> sum=0, cout=1, ovf=1. Then a=0, b=0, cin=1 -> sum=1, cout=0, ovf=0.
- Backpressure: a=3, b=4; hold out_ready=0 for 6 cycles with in_valid=1, a=9 pending -> sum stays 7, out_valid stays 1, in_ready stays 0. Raise out_ready -> a=9 accepted on the same edge; next result follows 4 clocks later.
- Back-to-back: in_valid and out_ready held high with 8 random operand pairs -> one result every 5 clocks, each equal to a+b+cin mod 16 with correct cout/ovf.
- Reset mid-operation: accept a=6, b=6; drop rst_n asynchronously after 2 clocks -> out_valid, sum, cout, ovf go to 0 and in_ready to 1 without a clock edge. No stale result appears after reset release.
- Round-trip: for all 256 (a, b) pairs, feed d = a - b (mod 16) from the multibit subtractor with b and cin=0 -> sum == a on every transaction.

Source files
------------

// File: rtl/serial_adder_multbit_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface serial_adder_multbit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_multbit.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first.
// Operands and result each pass through a valid/ready handshake.
module serial_adder_multbit #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_adder_multbit_if.slave bus
);
    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             accept;

    // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
    always_comb begin
        bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_nxt   = {bit_s, sum_sr};
    end

    // Accepting in DONE on the consuming edge gives back-to-back operation.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (accept) begin
            a_sr        <= bus.a;
            b_sr        <= bus.b;
            carry       <= bus.cin;
            cnt         <= '0;
            sum_sr      <= '0;
            out_valid_q <= 1'b0;
            state       <= SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_nxt;
                    sum_sr <= sum_nxt[WIDTH-1:1];
                    if (cnt == LAST) begin
                        // carry here is the carry into the MSB slice
                        cnt         <= '0;
                        sum_q       <= sum_nxt;
                        cout_q      <= carry_nxt;
                        ovf_q       <= carry ^ carry_nxt;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_multbit.sv
// Self-checking bench for serial_adder_multbit: directed vector table, handshake
// corner sequences and a scoreboard that compares every delivered result.
module tb_serial_adder_multbit;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    res_t sb[$];

    serial_adder_multbit_if #(.WIDTH(W)) bus ();

    serial_adder_multbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        res_t       r;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic vec_t mk_vec(input int a, input int b, input int cin,
                                    input int sum, input int cout, input int ovf);
        vec_t v;
        v.a        = W'(a);
        v.b        = W'(b);
        v.cin      = 1'(cin);
        v.exp.sum  = W'(sum);
        v.exp.cout = 1'(cout);
        v.exp.ovf  = 1'(ovf);
        return v;
    endfunction

    // Scoreboard: one comparison per result handshake.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("result_expected", 32'(sb.size() != 0), 32'd1);
            end else begin
                e = sb.pop_front();
                check("result", 32'({bus.sum, bus.cout, bus.ovf}), 32'(e));
            end
        end
    end

    // Present operands, wait (bounded) for acceptance, log the expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input res_t exp);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'(ok), 32'd1);
        end else begin
            @(posedge clk);
            accept_cyc = cyc;
            sb.push_back(exp);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Called just after an accepting edge: out_valid must rise exactly W clocks later.
    task automatic wait_latency(input string name);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_out_valid"}, 32'(bus.out_valid), 32'(i == W));
            check({name, "_in_ready"}, 32'(bus.in_ready), (i == W) ? 32'(bus.out_ready) : 32'd0);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({name, "_sum"},       32'(bus.sum),       32'd0);
        check({name, "_cout"},      32'(bus.cout),      32'd0);
        check({name, "_ovf"},       32'(bus.ovf),       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs[8];
        res_t         r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] d;
        logic         rc;
        int           prev;

        vecs[0] = mk_vec( 7,  5, 0, 12, 0, 1);
        vecs[1] = mk_vec(15,  1, 0,  0, 1, 0);
        vecs[2] = mk_vec( 8,  8, 0,  0, 1, 1);
        vecs[3] = mk_vec( 0,  0, 1,  1, 0, 0);
        vecs[4] = mk_vec( 4,  3, 1,  8, 0, 1);
        vecs[5] = mk_vec(15, 15, 1, 15, 1, 0);
        vecs[6] = mk_vec( 9,  6, 1,  0, 1, 0);
        vecs[7] = mk_vec(10, 11, 0,  5, 1, 1);

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("after_reset");

        // First vector with the consumer stalled: in_ready must stay low for W clocks.
        send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].exp);
        wait_latency("vec0");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        for (int i = 1; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
            wait_latency("vec");
        end

        // Back-to-back: accepts must be exactly W+1 clocks apart.
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, model(ra, rb, rc));
            if (k > 0) check("b2b_spacing", 32'(accept_cyc - prev), 32'(W + 1));
            prev = accept_cyc;
        end
        wait_latency("b2b_last");

        // Backpressure: result 3+4 held while 9+8 waits at the input.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(4'd3, 4'd4, 1'b0, model(4'd3, 4'd4, 1'b0));
        wait_latency("bp");
        fork
            send(4'd9, 4'd8, 1'b0, model(4'd9, 4'd8, 1'b0));
            begin
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                    check("bp_hold_sum",   32'(bus.sum),       32'd7);
                    check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_latency("bp_next");

        // Asynchronous reset two clocks into SHIFT; last result (sum 1, cout 1, ovf 1) must clear.
        send(4'd6, 4'd6, 1'b0, model(4'd6, 4'd6, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_shift");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(bus.out_valid), 32'd0);
            check("no_stale_ready", 32'(bus.in_ready),  32'd1);
        end

        // Asynchronous reset while a result is being presented.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(4'd5, 4'd1, 1'b0, model(4'd5, 4'd1, 1'b0));
        wait_latency("rst_done_pre");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_done");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Round trip: (a - b) + b must give back a for every pair.
        for (int ia = 0; ia < (1 << W); ia++) begin
            for (int ib = 0; ib < (1 << W); ib++) begin
                ra    = W'(ia);
                rb    = W'(ib);
                d     = ra - rb;
                r     = model(d, rb, 1'b0);
                r.sum = ra;
                send(d, rb, 1'b0, r);
            end
        end
        wait_latency("rt_last");

        @(posedge clk);
        #1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
